camera_frame_receiver: RTL and testbench
========================================

Name: camera_frame_receiver

Overview:
- Receiving end of the camera control interface.
- Monitors erase, expose, NRE_1, NRE_2 and ADC as driven by camera_controller, checks that the frame sequence is legal, and measures the exposure length in clocks.
- On each ADC conversion strobe it captures the digitised row from the 2-row pixel array and presents it, tagged with its row, to the image datapath.
- Flags any out-of-order protocol event.

Parameters:
- ADC_W, 8, bits per pixel sample.
- COLS, 2, pixels per row; all pixels of a row arrive in parallel on adc_data.
- EXP_W, 8, width of the exposure-cycle counter; the counter saturates.
- FCNT_W, 8, width of the frame counter; the counter wraps.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- erase  in  1  pixel erase command, active high.
- expose  in  1  exposure window, active high.
- NRE_1  in  1  row 0 read enable, active low.
- NRE_2  in  1  row 1 read enable, active low.
- ADC  in  1  conversion strobe; capture on its rising edge.
- adc_data  in  COLS*ADC_W  converted row, column 0 in the LSBs.
- row_data  out  COLS*ADC_W  captured row.
- row_valid  out  1  one-cycle pulse, row_data valid.
- row_sel  out  1  row of row_data: 0 = NRE_1, 1 = NRE_2.
- exp_time  out  EXP_W  cycles expose was high in the last completed exposure.
- frame_done  out  1  one-cycle pulse when a frame completes.
- frame_count  out  FCNT_W  completed frames.
- proto_err  out  1  one-cycle pulse per protocol violation.
- state_dbg  out  3  current FSM state encoding.

Behaviour:
- Reset (rst=1 at an edge): state IDLE. All outputs 0; row_data 0. Internal adc_q 0, row-done flags 0, exposure counter 0. Reset overrides all other inputs at that edge.
- ADC edge detect: adc_q holds ADC from the previous edge. A rising edge is detected at edge N when ADC=1 and adc_q=0.
- FSM states and encoding: IDLE=0, ERASE=1, ARMED=2, EXPOSE=3, READOUT=4.
- IDLE:
  - erase=1 -> ERASE.
  - expose=1, NRE_1=0, NRE_2=0, or an ADC rise -> proto_err, stay IDLE.
- ERASE:
  - erase=1 and expose=1 together -> proto_err, stay ERASE.
  - erase=0 and expose=0 -> ARMED.
  - erase=0 and expose=1 -> EXPOSE; the counter loads 1.
- ARMED:
  - expose=1 -> EXPOSE; the counter loads 1.
  - NRE low or ADC rise -> proto_err, stay ARMED.
- EXPOSE:
  - expose=1 -> counter +1, saturating at 2^EXP_W-1.
  - expose=0 -> exp_time <= counter; clear row flags; -> READOUT.
  - NRE low or ADC rise while in EXPOSE -> proto_err.
- READOUT, on ADC rise:
  - NRE_1=0 and NRE_2=1, row0 not done: capture, row_sel=0, set row0 done.
  - NRE_2=0 and NRE_1=1, row0 done and row1 not done: capture, row_sel=1, set row1 done.
  - Any other case (both NRE low, both high, row1 before row0, duplicate row): proto_err, no capture.
  - expose=1 in READOUT -> proto_err.
- Capture: at edge N, row_data <= adc_data sampled at edge N, and row_sel is set. row_valid is high for exactly the cycle after edge N. Latency is 1 clock.
- Frame completion: in READOUT with both rows done and NRE_1=NRE_2=1 -> frame_done pulse, frame_count +1 (wraps FCNT_W), -> IDLE. If the capture and both-NRE-high occur at the same edge, frame_done is one edge later.
- Abort: erase=1 in ARMED, EXPOSE or READOUT -> proto_err, go to ERASE, discard row flags. exp_time and frame_count are unchanged.
- Error count: proto_err pulses once per offending edge. Multiple violations at one edge give a single pulse.
- Between captures, row_data holds its last value.

Test Plan:
- Reset: rst=1 for 1 cycle mid-READOUT -> next cycle all outputs 0, state_dbg=0, no frame_done.
- Nominal frame:
  - Stimulus: erase 2 cycles, expose 5 cycles, NRE_1=0 with ADC pulse and adc_data=16'hA55A, NRE_1=1, NRE_2=0 with ADC pulse and adc_data=16'h1234, NRE_2=1.
  - Response: exp_time=5; row_valid pulses with row_sel=0/16'hA55A then row_sel=1/16'h1234, each 1 cycle after its ADC rise; frame_done once; frame_count=1.
- Saturation: with EXP_W=8, hold expose 300 cycles -> exp_time=255.
- Order errors:
  - ADC rise with NRE_2=0 before row 0 -> proto_err=1, no row_valid.
  - ADC rise with both NRE low -> proto_err=1, no row_valid.
  - ADC held high 3 cycles -> only one capture.
- Abort: erase=1 after the row-0 capture -> proto_err=1, state_dbg=1. A following full frame completes with frame_count incremented by 1 and no stale row flags.
- Idle noise: expose=1 while IDLE -> proto_err=1, state_dbg stays 0. frame_count wraps 255 -> 0 after 256 frames.

Source files
------------

// File: rtl/camera_frame_receiver.sv
// Receiver for the camera control interface: checks the erase/expose/readout sequence,
// measures exposure length and captures the two ADC rows, tagging each with its row.
module camera_frame_receiver #(
  parameter int ADC_W  = 8,
  parameter int COLS   = 2,
  parameter int EXP_W  = 8,
  parameter int FCNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  erase,
  input  logic                  expose,
  input  logic                  NRE_1,
  input  logic                  NRE_2,
  input  logic                  ADC,
  input  logic [COLS*ADC_W-1:0] adc_data,
  output logic [COLS*ADC_W-1:0] row_data,
  output logic                  row_valid,
  output logic                  row_sel,
  output logic [EXP_W-1:0]      exp_time,
  output logic                  frame_done,
  output logic [FCNT_W-1:0]     frame_count,
  output logic                  proto_err,
  output logic [2:0]            state_dbg
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, ERASE = 3'd1, ARMED = 3'd2, EXPOSE = 3'd3, READOUT = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic adc_q, r0_done, r1_done;
  logic [EXP_W-1:0] exp_cnt;
  logic adc_rise, nre_any;
  logic err, cap0, cap1, done, exp_load, exp_inc, exp_latch, flags_clr;

  assign adc_rise  = ADC & ~adc_q;
  assign nre_any   = ~NRE_1 | ~NRE_2;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (erase) state_nxt = ERASE;
      ERASE:   if (!erase) state_nxt = expose ? EXPOSE : ARMED;
      ARMED:   if (erase) state_nxt = ERASE;
               else if (expose) state_nxt = EXPOSE;
      EXPOSE:  if (erase) state_nxt = ERASE;
               else if (!expose) state_nxt = READOUT;
      READOUT: if (erase) state_nxt = ERASE;
               else if (r0_done && r1_done && NRE_1 && NRE_2) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-edge actions; erase outside IDLE/ERASE aborts the frame and wins over everything else.
  always_comb begin
    err       = 1'b0;
    cap0      = 1'b0;
    cap1      = 1'b0;
    done      = 1'b0;
    exp_load  = 1'b0;
    exp_inc   = 1'b0;
    exp_latch = 1'b0;
    flags_clr = 1'b0;
    case (state)
      IDLE:  err = ~erase & (expose | nre_any | adc_rise);
      ERASE: begin
        err      = erase & expose;
        exp_load = ~erase & expose;
      end
      ARMED, EXPOSE, READOUT: begin
        if (erase) begin
          err       = 1'b1;
          flags_clr = 1'b1;
        end else if (state == ARMED) begin
          err      = nre_any | adc_rise;
          exp_load = expose;
        end else if (state == EXPOSE) begin
          err       = nre_any | adc_rise;
          exp_inc   = expose;
          exp_latch = ~expose;
          flags_clr = ~expose;
        end else begin
          done = r0_done & r1_done & NRE_1 & NRE_2;
          cap0 = adc_rise & ~NRE_1 & NRE_2 & ~r0_done;
          cap1 = adc_rise & ~NRE_2 & NRE_1 & r0_done & ~r1_done;
          err  = expose | (adc_rise & ~cap0 & ~cap1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adc_q       <= 1'b0;
      r0_done     <= 1'b0;
      r1_done     <= 1'b0;
      exp_cnt     <= '0;
      exp_time    <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
      proto_err   <= 1'b0;
      row_valid   <= 1'b0;
      row_sel     <= 1'b0;
      row_data    <= '0;
    end else begin
      adc_q      <= ADC;
      proto_err  <= err;
      frame_done <= done;
      row_valid  <= cap0 | cap1;
      if (done) frame_count <= frame_count + 1'b1;
      if (exp_load) exp_cnt <= EXP_W'(1);
      else if (exp_inc && exp_cnt != '1) exp_cnt <= exp_cnt + 1'b1;
      if (exp_latch) exp_time <= exp_cnt;
      if (flags_clr) begin
        r0_done <= 1'b0;
        r1_done <= 1'b0;
      end else begin
        if (cap0) r0_done <= 1'b1;
        if (cap1) r1_done <= 1'b1;
      end
      if (cap0 | cap1) begin
        row_data <= adc_data;
        row_sel  <= cap1;
      end
    end
  end
endmodule

// File: tb/tb_camera_frame_receiver.sv
// Scoreboard bench: a rule-level model predicts row captures, frame completions, errors
// and state per edge; a negedge monitor pops and compares whenever the DUT pulses.
module tb_camera_frame_receiver;
  logic clk = 1'b0;
  logic rst, erase, expose, NRE_1, NRE_2, ADC;
  logic [15:0] adc_data, row_data;
  logic row_valid, row_sel, frame_done, proto_err;
  logic [7:0] exp_time, frame_count;
  logic [2:0] state_dbg;

  camera_frame_receiver dut (
    .clk(clk), .rst(rst), .erase(erase), .expose(expose), .NRE_1(NRE_1), .NRE_2(NRE_2),
    .ADC(ADC), .adc_data(adc_data), .row_data(row_data), .row_valid(row_valid),
    .row_sel(row_sel), .exp_time(exp_time), .frame_done(frame_done),
    .frame_count(frame_count), .proto_err(proto_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int checks = 0;
  int failures = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: actual=%0h expected=%0h", nm, edges, act, exp);
    end
  endtask

  typedef struct { int tag; logic sel; logic [15:0] data; } row_ev_t;
  typedef struct { int tag; int cnt; int et; } done_ev_t;
  typedef struct { int tag; int st; } st_ev_t;
  row_ev_t  rq[$];
  done_ev_t dq[$];
  st_ev_t   sq[$];
  int       eq[$];

  // Reference model: phase numbers are the published state encoding.
  localparam int P_IDLE = 0, P_ERASE = 1, P_ARMED = 2, P_EXPOSE = 3, P_READOUT = 4;
  int m_phase = 0, m_cnt = 0, m_exp = 0, m_fc = 0;
  bit m_r0 = 0, m_r1 = 0, m_adc = 0;

  task automatic mstep(input bit r, e, x, n1, n2, a, input logic [15:0] d);
    int t, nxt;
    bit rise, err, nre;
    row_ev_t rv;
    done_ev_t dv;
    st_ev_t sv;
    t = edges + 1;
    sv.tag = t;
    if (r) begin
      m_phase = P_IDLE; m_cnt = 0; m_exp = 0; m_fc = 0; m_r0 = 0; m_r1 = 0; m_adc = 0;
      sv.st = 0;
      sq.push_back(sv);
      return;
    end
    rise = a && !m_adc;
    m_adc = a;
    nre = !n1 || !n2;
    err = 0;
    nxt = m_phase;
    if (m_phase == P_IDLE) begin
      if (e) nxt = P_ERASE;
      else if (x || nre || rise) err = 1;
    end else if (m_phase == P_ERASE) begin
      if (e && x) err = 1;
      else if (!e && x) begin nxt = P_EXPOSE; m_cnt = 1; end
      else if (!e) nxt = P_ARMED;
    end else if (e) begin
      err = 1; nxt = P_ERASE; m_r0 = 0; m_r1 = 0;
    end else if (m_phase == P_ARMED) begin
      if (nre || rise) err = 1;
      if (x) begin nxt = P_EXPOSE; m_cnt = 1; end
    end else if (m_phase == P_EXPOSE) begin
      if (nre || rise) err = 1;
      if (x) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      else begin m_exp = m_cnt; m_r0 = 0; m_r1 = 0; nxt = P_READOUT; end
    end else begin
      if (x) err = 1;
      if (m_r0 && m_r1 && n1 && n2) begin
        m_fc = (m_fc + 1) % 256;
        dv.tag = t; dv.cnt = m_fc; dv.et = m_exp;
        dq.push_back(dv);
        nxt = P_IDLE;
      end
      if (rise) begin
        rv.tag = t; rv.data = d;
        if (!n1 && n2 && !m_r0) begin rv.sel = 0; rq.push_back(rv); m_r0 = 1; end
        else if (n1 && !n2 && m_r0 && !m_r1) begin rv.sel = 1; rq.push_back(rv); m_r1 = 1; end
        else err = 1;
      end
    end
    if (err) eq.push_back(t);
    m_phase = nxt;
    sv.st = nxt;
    sq.push_back(sv);
  endtask

  // One clock of stimulus, applied 3 time units after a rising edge.
  task automatic drv(input bit r, e, x, n1, n2, a, input logic [15:0] d);
    rst = r; erase = e; expose = x; NRE_1 = n1; NRE_2 = n2; ADC = a; adc_data = d;
    mstep(r, e, x, n1, n2, a, d);
    @(posedge clk);
    #3;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(0, 0, 0, 1, 1, 0, 16'h0);
  endtask

  task automatic frame(input int er, ex, input logic [15:0] d0, d1, input int h0, h1, gap);
    repeat (er) drv(0, 1, 0, 1, 1, 0, 16'h0);
    repeat (ex) drv(0, 0, 1, 1, 1, 0, 16'h0);
    drv(0, 0, 0, 1, 1, 0, 16'h0);
    idle(gap);
    drv(0, 0, 0, 0, 1, 1, d0);
    repeat (h0 - 1) drv(0, 0, 0, 0, 1, 1, ~d0);
    drv(0, 0, 0, 1, 1, 0, 16'h0);
    drv(0, 0, 0, 1, 0, 1, d1);
    repeat (h1 - 1) drv(0, 0, 0, 1, 0, 1, ~d1);
    drv(0, 0, 0, 1, 1, 0, 16'h0);
  endtask

  always @(negedge clk) begin
    while (rq.size() > 0 && rq[0].tag < edges) begin
      cmp("row_valid_missing", {31'b0, row_valid}, 32'd1); void'(rq.pop_front());
    end
    if (row_valid === 1'b1) begin
      if (rq.size() > 0 && rq[0].tag == edges) begin
        cmp("row_sel", {31'b0, row_sel}, {31'b0, rq[0].sel});
        cmp("row_data", {16'b0, row_data}, {16'b0, rq[0].data});
        void'(rq.pop_front());
      end else cmp("row_valid_unexpected", {31'b0, row_valid}, 32'd0);
    end else if (rq.size() > 0 && rq[0].tag == edges) begin
      cmp("row_valid_missing", {31'b0, row_valid}, 32'd1); void'(rq.pop_front());
    end

    while (dq.size() > 0 && dq[0].tag < edges) begin
      cmp("frame_done_missing", {31'b0, frame_done}, 32'd1); void'(dq.pop_front());
    end
    if (frame_done === 1'b1) begin
      if (dq.size() > 0 && dq[0].tag == edges) begin
        cmp("frame_count", {24'b0, frame_count}, dq[0].cnt);
        cmp("exp_time", {24'b0, exp_time}, dq[0].et);
        void'(dq.pop_front());
      end else cmp("frame_done_unexpected", {31'b0, frame_done}, 32'd0);
    end else if (dq.size() > 0 && dq[0].tag == edges) begin
      cmp("frame_done_missing", {31'b0, frame_done}, 32'd1); void'(dq.pop_front());
    end

    while (eq.size() > 0 && eq[0] < edges) begin
      cmp("proto_err_missing", {31'b0, proto_err}, 32'd1); void'(eq.pop_front());
    end
    if (proto_err === 1'b1) begin
      if (eq.size() > 0 && eq[0] == edges) void'(eq.pop_front());
      else cmp("proto_err_unexpected", {31'b0, proto_err}, 32'd0);
    end else if (eq.size() > 0 && eq[0] == edges) begin
      cmp("proto_err_missing", {31'b0, proto_err}, 32'd1); void'(eq.pop_front());
    end

    while (sq.size() > 0 && sq[0].tag <= edges) begin
      if (sq[0].tag == edges) cmp("state_dbg", {29'b0, state_dbg}, sq[0].st);
      void'(sq.pop_front());
    end
  end

  int fc0;

  initial begin
    rst = 1; erase = 0; expose = 0; NRE_1 = 1; NRE_2 = 1; ADC = 0; adc_data = 16'h0;
    repeat (2) @(posedge clk);
    #3;

    // Reset in the middle of readout, right after a row-0 capture
    drv(0, 1, 0, 1, 1, 0, 16'h0);
    repeat (3) drv(0, 0, 1, 1, 1, 0, 16'h0);
    drv(0, 0, 0, 1, 1, 0, 16'h0);
    drv(0, 0, 0, 0, 1, 1, 16'hBEEF);
    drv(1, 0, 0, 1, 1, 0, 16'h0);
    cmp("rst_row_valid", {31'b0, row_valid}, 32'd0);
    cmp("rst_row_data", {16'b0, row_data}, 32'd0);
    cmp("rst_row_sel", {31'b0, row_sel}, 32'd0);
    cmp("rst_exp_time", {24'b0, exp_time}, 32'd0);
    cmp("rst_frame_done", {31'b0, frame_done}, 32'd0);
    cmp("rst_frame_count", {24'b0, frame_count}, 32'd0);
    cmp("rst_proto_err", {31'b0, proto_err}, 32'd0);
    cmp("rst_state", {29'b0, state_dbg}, 32'd0);

    // Nominal frame
    frame(2, 5, 16'hA55A, 16'h1234, 1, 1, 0);
    cmp("nom_exp_time", {24'b0, exp_time}, 32'd5);
    cmp("nom_frame_count", {24'b0, frame_count}, 32'd1);
    idle(2);

    // Exposure counter saturation
    frame(1, 300, 16'h0F0F, 16'hF0F0, 1, 1, 1);
    cmp("sat_exp_time", {24'b0, exp_time}, 32'd255);

    // Order errors, then a held ADC strobe that must capture once
    drv(0, 1, 0, 1, 1, 0, 16'h0);
    repeat (2) drv(0, 0, 1, 1, 1, 0, 16'h0);
    drv(0, 0, 0, 1, 1, 0, 16'h0);
    drv(0, 0, 0, 1, 0, 1, 16'h1111);
    cmp("order_row1_first_err", {31'b0, proto_err}, 32'd1);
    cmp("order_row1_first_novalid", {31'b0, row_valid}, 32'd0);
    drv(0, 0, 0, 1, 1, 0, 16'h0);
    drv(0, 0, 0, 0, 0, 1, 16'h2222);
    cmp("order_both_low_err", {31'b0, proto_err}, 32'd1);
    cmp("order_both_low_novalid", {31'b0, row_valid}, 32'd0);
    drv(0, 0, 0, 1, 1, 0, 16'h0);
    repeat (3) drv(0, 0, 0, 0, 1, 1, 16'h3333);
    drv(0, 0, 0, 1, 1, 0, 16'h0);
    drv(0, 0, 0, 1, 0, 1, 16'h4444);
    drv(0, 0, 0, 1, 1, 0, 16'h0);
    idle(1);

    // Abort after row 0, then a clean frame
    drv(0, 1, 0, 1, 1, 0, 16'h0);
    repeat (4) drv(0, 0, 1, 1, 1, 0, 16'h0);
    drv(0, 0, 0, 1, 1, 0, 16'h0);
    drv(0, 0, 0, 0, 1, 1, 16'h5555);
    drv(0, 0, 0, 1, 1, 0, 16'h0);
    fc0 = m_fc;
    drv(0, 1, 0, 1, 1, 0, 16'h0);
    cmp("abort_err", {31'b0, proto_err}, 32'd1);
    cmp("abort_state", {29'b0, state_dbg}, 32'd1);
    frame(1, 3, 16'h6666, 16'h7777, 1, 1, 0);
    cmp("abort_next_count", {24'b0, frame_count}, (fc0 + 1) % 256);

    // Noise while idle
    drv(0, 0, 1, 1, 1, 0, 16'h0);
    cmp("idle_noise_err", {31'b0, proto_err}, 32'd1);
    cmp("idle_noise_state", {29'b0, state_dbg}, 32'd0);
    idle(1);

    // Frame counter wrap
    fc0 = m_fc;
    repeat (256) frame(1, 1, 16'($urandom), 16'($urandom), 1, 1, 0);
    cmp("fcount_wrap", {24'b0, frame_count}, fc0);

    // Randomized frames mixed with protocol noise
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat (8) drv(0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                       $urandom_range(0, 1) == 1, 16'($urandom));
      end else begin
        frame($urandom_range(1, 3), $urandom_range(1, 20), 16'($urandom), 16'($urandom),
              $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 2));
      end
      idle($urandom_range(0, 2));
    end

    idle(3);
    cmp("rows_left", rq.size(), 32'd0);
    cmp("frames_left", dq.size(), 32'd0);
    cmp("errs_left", eq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
